// File: rtl/reg_bank_access_ctrl_pkg.sv
// Shared types for the register-bank request sequencer.
// RD_SIGN_EXT_EN: when defined, 8-bit reads are sign-extended instead of zero-extended.
package reg_bank_pkg;

    localparam int REG_COUNT = 8;
    localparam int REG_W     = $clog2(REG_COUNT);

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_e;

    typedef struct packed {
        op_e              write;
        logic [REG_W-1:0] reg_sel;
        logic             size;
        logic             high;
        logic             alt;
        logic [15:0]      wdata;
    } bank_req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        TURN
    } state_e;

    // Byte-lane selection and extension of a sampled bus word.
    function automatic logic [15:0] rd_align(input logic size, input logic high,
                                             input logic [15:0] data);
        logic [7:0] b;
        b = high ? data[15:8] : data[7:0];
        if (size) return data;
`ifdef RD_SIGN_EXT_EN
        return {{8{b[7]}}, b};
`else
        return {8'h00, b};
`endif
    endfunction

endpackage

// File: rtl/reg_bank_access_ctrl_if.sv
// Request, response and bank-pin bundle of the register-bank sequencer.
interface reg_bank_access_ctrl_if;
    import reg_bank_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [REG_W-1:0] req_reg;
    logic             req_size;
    logic             req_high;
    logic             req_alt;
    logic [15:0]      req_wdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_write;
    logic [15:0]      rsp_data;

    logic [REG_W-1:0] bank_select_reg;
    logic             bank_size;
    logic             bank_high_low;
    logic             bank_data_h;
    logic             bank_read_write;
    logic [15:0]      bank_data_out;
    logic             bank_data_oe;
    logic [15:0]      bank_data_in;

    modport slave (
        input  req_valid, req_write, req_reg, req_size, req_high, req_alt, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_data,
        input  rsp_ready,
        output bank_select_reg, bank_size, bank_high_low, bank_data_h, bank_read_write,
        output bank_data_out, bank_data_oe,
        input  bank_data_in
    );

    modport master (
        output req_valid, req_write, req_reg, req_size, req_high, req_alt, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_data,
        output rsp_ready,
        input  bank_select_reg, bank_size, bank_high_low, bank_data_h, bank_read_write,
        input  bank_data_out, bank_data_oe,
        output bank_data_in
    );

endinterface

// File: rtl/reg_bank_access_ctrl_req_fifo.sv
// Synchronous request FIFO; flags come straight from registered pointers.
module req_fifo
    import reg_bank_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  bank_req_t push_data,
    input  logic      pop,
    output bank_req_t pop_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    bank_req_t     mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/reg_bank_access_ctrl.sv
// Register-bank request sequencer: FIFO-buffered requests, bank pin sequencing with bus turnaround.
// RD_SIGN_EXT_EN selects sign extension of 8-bit reads (see reg_bank_pkg::rd_align).
module reg_bank_access_ctrl
    import reg_bank_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_bank_access_ctrl_if.slave  io
);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 2);

    state_e      state;
    state_e      state_nx;
    bank_req_t   cur;
    bank_req_t   head;
    bank_req_t   in_req;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        capture;
    logic        drive;
    logic        is_wr;
    logic [1:0]  wait_cnt;
    logic [15:0] rsp_data_q;
    logic        rsp_write_q;

    assign in_req = '{write:   op_e'(io.req_write),
                      reg_sel: io.req_reg,
                      size:    io.req_size,
                      high:    io.req_high,
                      alt:     io.req_alt,
                      wdata:   io.req_wdata};

    assign push         = io.req_valid && !full;
    assign io.req_ready = !full;

    req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign is_wr   = (cur.write == WRITE);
    assign capture = (state == ISSUE && !is_wr && READ_LAT == 1) ||
                     (state == WAIT && wait_cnt == WAIT_LAST);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (is_wr || READ_LAT == 1) state_nx = RESP;
                else                        state_nx = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nx = RESP;
            end
            RESP: begin
                if (io.rsp_ready) begin
                    if (is_wr) begin
                        state_nx = TURN;
                    end else if (!empty) begin
                        pop      = 1'b1;
                        state_nx = ISSUE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            TURN: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur         <= '0;
            wait_cnt    <= '0;
            rsp_data_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (pop) cur <= head;
            if (capture) begin
                rsp_data_q  <= rd_align(cur.size, cur.high, io.bank_data_in);
                rsp_write_q <= 1'b0;
            end else if (state == ISSUE && is_wr) begin
                rsp_data_q  <= '0;
                rsp_write_q <= 1'b1;
            end
        end
    end

    assign io.rsp_valid = (state == RESP);
    assign io.rsp_write = rsp_write_q;
    assign io.rsp_data  = rsp_data_q;

    // Pins are pure decodes of registered state so reset clears them (and oe) at once.
    assign drive              = (state == ISSUE) || (state == WAIT);
    assign io.bank_select_reg = drive ? cur.reg_sel : '0;
    assign io.bank_size       = drive && cur.size;
    assign io.bank_high_low   = drive && !cur.size && cur.high;
    assign io.bank_data_h     = drive && cur.alt;
    assign io.bank_read_write = drive && is_wr;
    assign io.bank_data_oe    = (state == ISSUE) && is_wr;
    assign io.bank_data_out   = !(drive && is_wr) ? 16'h0000 :
                                cur.size ? cur.wdata : {cur.wdata[7:0], cur.wdata[7:0]};

endmodule

// File: tb/tb_reg_bank_access_ctrl.sv
// Self-checking bench for reg_bank_access_ctrl: directed latency/turnaround sequences,
// a vector table, back-pressure, mid-transaction reset and randomized traffic vs a register model.
module tb_reg_bank_access_ctrl;
    import reg_bank_pkg::*;

    localparam int DEPTH = 4;
    localparam int RL    = 3;

    typedef struct {
        logic        w;
        logic [15:0] d;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [2:0]  r;
        logic        sz;
        logic        hi;
        logic        alt;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    reg_bank_access_ctrl_if io ();

    reg_bank_access_ctrl #(.FIFO_DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Bank model: data becomes valid RL-1 cycles after the read controls settle.
    logic [15:0] bank_mem [8] = '{default: 16'h0000};
    logic [15:0] ref_mem  [8] = '{default: 16'h0000};
    rsp_t        exp_q [$];
    logic [6:0]  prev_ctl = '0;
    int          age_q = 0;
    int          age;
    wire  [6:0]  ctl  = {io.bank_select_reg, io.bank_size, io.bank_high_low,
                         io.bank_data_h, io.bank_read_write};
    wire  [15:0] bus_w = io.bank_data_oe ? io.bank_data_out : 16'hDEAD;

    always_comb begin
        age = (ctl == prev_ctl) ? age_q + 1 : 0;
        io.bank_data_in = (!io.bank_read_write && age >= RL - 1) ?
                          bank_mem[io.bank_select_reg] : 16'hDEAD;
    end

    always @(posedge clk) begin
        prev_ctl <= ctl;
        age_q    <= age;
        if (io.bank_read_write) begin
            if (io.bank_size)          bank_mem[io.bank_select_reg]       <= bus_w;
            else if (io.bank_high_low) bank_mem[io.bank_select_reg][15:8] <= bus_w[15:8];
            else                       bank_mem[io.bank_select_reg][7:0]  <= bus_w[7:0];
        end
    end

    function automatic logic [15:0] sx(input logic [7:0] b);
`ifdef RD_SIGN_EXT_EN
        return {{8{b[7]}}, b};
`else
        return {8'h00, b};
`endif
    endfunction

    // Reference: apply requests in acceptance order to an array of registers.
    function automatic logic [15:0] model_apply(input logic w, input logic [2:0] r, input logic sz,
                                                input logic hi, input logic [15:0] wd);
        logic [15:0] v;
        v = ref_mem[r];
        if (w) begin
            if (sz)      ref_mem[r]       = wd;
            else if (hi) ref_mem[r][15:8] = wd[7:0];
            else         ref_mem[r][7:0]  = wd[7:0];
            return 16'h0000;
        end
        if (sz) return v;
        return sx(hi ? v[15:8] : v[7:0]);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string tag, input logic [2:0] sel, input logic sz, input logic hl,
                            input logic dh, input logic rw, input logic oe, input logic [15:0] dout);
        chk({tag, "_sel"},  16'(io.bank_select_reg), 16'(sel));
        chk({tag, "_size"}, 16'(io.bank_size),       16'(sz));
        chk({tag, "_hl"},   16'(io.bank_high_low),   16'(hl));
        chk({tag, "_dh"},   16'(io.bank_data_h),     16'(dh));
        chk({tag, "_rw"},   16'(io.bank_read_write), 16'(rw));
        chk({tag, "_oe"},   16'(io.bank_data_oe),    16'(oe));
        chk({tag, "_dout"}, io.bank_data_out,        dout);
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic push(input logic w, input logic [2:0] r, input logic sz, input logic hi,
                        input logic alt, input logic [15:0] wd, input logic [15:0] exp);
        int n;
        n = 0;
        io.req_write = w;
        io.req_reg   = r;
        io.req_size  = sz;
        io.req_high  = hi;
        io.req_alt   = alt;
        io.req_wdata = wd;
        io.req_valid = 1'b1;
        while (!io.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!io.req_ready) begin
            chk("push_timeout", 16'(io.req_ready), 16'd1);
            io.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        io.req_valid = 1'b0;
        exp_q.push_back('{w, exp});
    endtask

    task automatic send(input logic w, input logic [2:0] r, input logic sz, input logic hi,
                        input logic alt, input logic [15:0] wd);
        push(w, r, sz, hi, alt, wd, model_apply(w, r, sz, hi, wd));
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", 16'(exp_q.size()), 16'd0);
    endtask

    vec_t tbl [13];

    initial begin
        int accepted;
        tbl[0]  = '{1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0000, sx(8'h80)};
        tbl[1]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8000};
        tbl[2]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000};
        tbl[3]  = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, sx(8'h34)};
        tbl[4]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8034};
        tbl[5]  = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
        tbl[6]  = '{1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, sx(8'hFF)};
        tbl[7]  = '{1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF};
        tbl[8]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h7F01, 16'h0000};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h007F};
        tbl[10] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, sx(8'hC3)};
        tbl[11] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 16'h5A5A, 16'h0000};
        tbl[12] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5A5A};

        io.req_valid = 1'b0;
        io.req_write = 1'b0;
        io.req_reg   = '0;
        io.req_size  = 1'b0;
        io.req_high  = 1'b0;
        io.req_alt   = 1'b0;
        io.req_wdata = '0;
        io.rsp_ready = 1'b1;

        // Response scoreboard and bus-hazard monitor.
        fork
            begin
                rsp_t        e;
                logic        held;
                logic [16:0] held_v;
                held = 1'b0;
                held_v = '0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        held = 1'b0;
                    end else begin
                        chk("oe_during_read", 16'(io.bank_data_oe & ~io.bank_read_write), 16'd0);
                        if (held) begin
                            chk("rsp_hold_valid", 16'(io.rsp_valid), 16'd1);
                            chk("rsp_hold_data", io.rsp_data, held_v[15:0]);
                        end
                        if (io.rsp_valid && io.rsp_ready) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_rsp", 16'(io.rsp_valid), 16'd0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("rsp_write", 16'(io.rsp_write), 16'(e.w));
                                chk("rsp_data", io.rsp_data, e.d);
                            end
                        end
                        held   = io.rsp_valid && !io.rsp_ready;
                        held_v = {io.rsp_write, io.rsp_data};
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 16'(io.req_ready), 16'd1);
        chk("rst_rsp_valid", 16'(io.rsp_valid), 16'd0);
        chk("rst_rsp_write", 16'(io.rsp_write), 16'd0);
        chk("rst_rsp_data", io.rsp_data, 16'h0000);
        chk_bank("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16-bit write: ISSUE one cycle after the FSM sees the entry, response the next.
        send(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 16'hA5C3);
        @(negedge clk);
        chk("wr_idle_oe", 16'(io.bank_data_oe), 16'd0);
        @(negedge clk);
        chk_bank("wr_issue", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3);
        @(negedge clk);
        chk("wr_rsp_valid", 16'(io.rsp_valid), 16'd1);
        chk("wr_rsp_write", 16'(io.rsp_write), 16'd1);
        chk("wr_rsp_data", io.rsp_data, 16'h0000);
        chk("wr_resp_oe", 16'(io.bank_data_oe), 16'd0);
        @(negedge clk);
        chk("turn_oe", 16'(io.bank_data_oe), 16'd0);
        chk("turn_rw", 16'(io.bank_read_write), 16'd0);
        chk("turn_valid", 16'(io.rsp_valid), 16'd0);
        @(posedge clk); #1;

        // Read latency: controls stable for RL cycles, response at edge N+1+RL.
        send(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < RL; i++) begin
            @(negedge clk);
            chk("rd_early_valid", 16'(io.rsp_valid), 16'd0);
            chk_bank("rd_hold", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
        @(negedge clk);
        chk("rd_lat_valid", 16'(io.rsp_valid), 16'd1);
        chk("rd_lat_data", io.rsp_data, 16'hA5C3);
        wait_drain(20);
        repeat (2) @(posedge clk);
        #1;

        // 8-bit high write replicates the byte on both lanes.
        send(1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 16'h0080);
        @(negedge clk);
        @(negedge clk);
        chk_bank("wr8_issue", 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8080);
        wait_drain(20);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            void'(model_apply(tbl[i].w, tbl[i].r, tbl[i].sz, tbl[i].hi, tbl[i].wd));
            push(tbl[i].w, tbl[i].r, tbl[i].sz, tbl[i].hi, tbl[i].alt, tbl[i].wd, tbl[i].exp);
            wait_drain(40);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: stall RESP, then FIFO takes exactly DEPTH more.
        io.rsp_ready = 1'b0;
        send(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !io.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_stalled_valid", 16'(io.rsp_valid), 16'd1);
        accepted = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (io.req_ready) begin
                send(i[0] ? 1'b0 : 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i));
                accepted++;
            end
        end
        chk("bp_accepts", 16'(accepted), 16'(DEPTH));
        chk("bp_ready_low", 16'(io.req_ready), 16'd0);
        io.rsp_ready = 1'b1;
        wait_drain(200);
        repeat (3) @(posedge clk);
        #1;

        // Reset while the first of three queued reads is in WAIT.
        send(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
        send(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0000);
        send(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("pre_rst_sel", 16'(io.bank_select_reg), 16'd5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_oe", 16'(io.bank_data_oe), 16'd0);
        chk("mid_rst_valid", 16'(io.rsp_valid), 16'd0);
        chk("mid_rst_ready", 16'(io.req_ready), 16'd1);
        chk("mid_rst_sel", 16'(io.bank_select_reg), 16'd0);
        chk("mid_rst_data", io.rsp_data, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_valid", 16'(io.rsp_valid), 16'd0);
        chk("post_rst_sel", 16'(io.bank_select_reg), 16'd0);

        // Randomized traffic with random consumer stalls.
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 16'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    io.rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        io.rsp_ready = 1'b1;
        wait_drain(1000);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
